// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand sequencer for an ARRAY_DIM x ARRAY_DIM output-stationary MAC
//   array. One k-slice per beat (a column of A and a row of B) is accepted on
//   two valid/ready streams. The two streams are joined so that neither one
//   transfers alone. Lane i is skewed by i cycles. A zero bubble is inserted
//   whenever the streams stall. The block runs num_tiles tiles of k_len beats.
//
// Ports
//   clk, reset (async, active-low)
//   start, k_len, num_tiles : job request, sampled in IDLE only
//   a_data/a_valid/a_ready  : A column stream, lane 0 in LSBs
//   b_data/b_valid/b_ready  : B row stream, lane 0 in LSBs
//   a_out, a_lane_vld, a_first : skewed west-edge operands, valid, k=0 tag
//   b_out, b_lane_vld          : skewed north-edge operands, valid
//   tile_done, done            : one-cycle pulses at tile end and job end
//   busy                       : high whenever not IDLE
module systolic_feeder #(
  parameter int ARRAY_DIM = 2,
  parameter int DATA_W    = 8,
  parameter int K_W       = 17,
  parameter int T_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_W-1:0]              k_len,
  input  logic [T_W-1:0]              num_tiles,
  input  logic [ARRAY_DIM*DATA_W-1:0] a_data,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [ARRAY_DIM*DATA_W-1:0] b_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  output logic [ARRAY_DIM*DATA_W-1:0] a_out,
  output logic [ARRAY_DIM*DATA_W-1:0] b_out,
  output logic [ARRAY_DIM-1:0]        a_lane_vld,
  output logic [ARRAY_DIM-1:0]        b_lane_vld,
  output logic [ARRAY_DIM-1:0]        a_first,
  output logic                        tile_done,
  output logic                        done,
  output logic                        busy
);

  localparam int DRN_W = $clog2(2 * ARRAY_DIM);
  // Drain covers the 2*ARRAY_DIM-2 cycles the last operand needs to reach
  // the far corner PE.
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(2 * ARRAY_DIM - 3);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, TILE_END, DONE} state_t;

  state_t           state;
  logic [K_W-1:0]   k_cnt;
  logic [K_W-1:0]   k_len_q;
  logic [T_W-1:0]   tile_cnt;
  logic [T_W-1:0]   num_q;
  logic [DRN_W-1:0] drain_cnt;

  logic beat;
  logic adv;
  logic first_beat;

  // The joint handshake: each side is ready only when the other side has data.
  assign a_ready    = (state == FEED) && b_valid;
  assign b_ready    = (state == FEED) && a_valid;
  assign beat       = (state == FEED) && a_valid && b_valid;
  assign adv        = (state == FEED) || (state == DRAIN);
  assign first_beat = beat && (k_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_cnt     <= '0;
      k_len_q   <= '0;
      tile_cnt  <= '0;
      num_q     <= '0;
      drain_cnt <= '0;
      tile_done <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_len_q  <= k_len;
            num_q    <= num_tiles;
            k_cnt    <= '0;
            tile_cnt <= '0;
            busy     <= 1'b1;
            if ((k_len == '0) || (num_tiles == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (beat) begin
            k_cnt <= k_cnt + K_W'(1);
            // k_len_q is nonzero here, so the compare never wraps.
            if (k_cnt == k_len_q - K_W'(1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DRN_W'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state     <= TILE_END;
            tile_done <= 1'b1;
          end
        end
        TILE_END: begin
          tile_cnt <= tile_cnt + T_W'(1);
          if (tile_cnt == num_q - T_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            k_cnt <= '0;
            state <= FEED;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    logic signed [DATA_W-1:0] a_p [0:i];
    logic signed [DATA_W-1:0] b_p [0:i];
    logic [i:0]               a_vld_p;
    logic [i:0]               b_vld_p;
    logic [i:0]               first_p;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s <= i; s++) begin
          a_p[s] <= '0;
          b_p[s] <= '0;
        end
        a_vld_p <= '0;
        b_vld_p <= '0;
        first_p <= '0;
      end else if (adv) begin
        // Stage p0: the input register. Stalls load a zero bubble so the
        // wavefront across lanes stays aligned.
        a_p[0]     <= beat ? $signed(a_data[i*DATA_W +: DATA_W]) : '0;
        b_p[0]     <= beat ? $signed(b_data[i*DATA_W +: DATA_W]) : '0;
        a_vld_p[0] <= beat;
        b_vld_p[0] <= beat;
        first_p[0] <= first_beat;
        // Stages p1..pi: lane-index skew.
        for (int s = 1; s <= i; s++) begin
          a_p[s]     <= a_p[s-1];
          b_p[s]     <= b_p[s-1];
          a_vld_p[s] <= a_vld_p[s-1];
          b_vld_p[s] <= b_vld_p[s-1];
          first_p[s] <= first_p[s-1];
        end
      end
    end

    assign a_out[i*DATA_W +: DATA_W] = a_p[i];
    assign b_out[i*DATA_W +: DATA_W] = b_p[i];
    assign a_lane_vld[i]             = a_vld_p[i];
    assign b_lane_vld[i]             = b_vld_p[i];
    assign a_first[i]                = first_p[i];
  end

endmodule
